pi_sampler: RTL and testbench



---
 rtl/pi_sampler_pkg.sv | 25 ++
 rtl/pi_sampler_lfsr.sv | 31 +++
 rtl/pi_sampler.sv | 235 +++++++++++++++++++++++
 tb/tb_pi_sampler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pi_sampler_pkg.sv
// Shared types and LFSR polynomial constants for the pi_sampler Monte Carlo engine.
package pi_sampler_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GEN   = 3'd1,
    CHECK = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Galois (right-shift) maximal-length tap masks
  localparam logic [31:0] TAPS_9  = 32'h0000_0110;
  localparam logic [31:0] TAPS_16 = 32'h0000_B400;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;

  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      9:       return TAPS_9;
      16:      return TAPS_16;
      default: return TAPS_32;
    endcase
  endfunction

endpackage

// File: rtl/pi_sampler_lfsr.sv
// Galois LFSR with synchronous reload; q exposes the low OUT_W bits of the next state.
module pi_lfsr #(
  parameter int           W     = 32,
  parameter int           OUT_W = 9,
  parameter logic [W-1:0] SEED  = '1,
  parameter logic [W-1:0] TAPS  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step,
  input  logic             load,
  output logic [OUT_W-1:0] q
);

  logic [W-1:0] q_q, q_d, q_next;

  always_comb begin
    q_next = {1'b0, q_q[W-1:1]} ^ (q_q[0] ? TAPS : '0);
    q_d    = q_q;
    if (load)      q_d = SEED;
    else if (step) q_d = q_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q_q <= SEED;
    else          q_q <= q_d;
  end

  assign q = q_next[OUT_W-1:0];

endmodule

// File: rtl/pi_sampler.sv
// Monte Carlo point generator for the pi display; optional ratio divider under PI_SAMPLER_RATIO_EN.
// state | meaning
// IDLE  | wait for enable && tick
// GEN   | step LFSRs, redraw until both candidates fall inside the square
// CHECK | classify latched point against the circle
// WRITE | hold point with wr_valid until wr_ready
// DONE  | SAMPLE_LIMIT reached, only clear leaves
module pi_sampler
  import pi_sampler_pkg::*;
#(
  parameter int                COORD_W      = 9,
  parameter int                LFSR_W       = 32,
  parameter int                RADIUS       = 240,
  parameter int                CNT_W        = 24,
  parameter int                SAMPLE_LIMIT = 0,
  parameter logic [LFSR_W-1:0] SEED_X       = 32'hAAAACCCC,
  parameter logic [LFSR_W-1:0] SEED_Y       = 32'hDECAFBAD
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick,
  input  logic               enable,
  input  logic               clear,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic               wr_inside,
  output logic [CNT_W-1:0]   total_count,
  output logic [CNT_W-1:0]   inside_count,
  output logic               done,
  output logic               overrun
`ifdef PI_SAMPLER_RATIO_EN
  ,
  output logic [15:0]        pi_est,
  output logic               pi_est_valid
`endif
);

  localparam logic [31:0]          TAPS_ALL = lfsr_taps(LFSR_W);
  localparam logic [COORD_W:0]     SIDE_C   = (COORD_W+1)'(2 * RADIUS);
  localparam logic [COORD_W:0]     RAD_C    = (COORD_W+1)'(RADIUS);
  localparam logic [2*COORD_W+2:0] RSQ_C    = (2*COORD_W+3)'(RADIUS * RADIUS);
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]     LIMIT_C  = CNT_W'(SAMPLE_LIMIT);

  state_t             state_q, state_d;
  logic [COORD_W-1:0] wr_x_q, wr_x_d, wr_y_q, wr_y_d, cand_x, cand_y;
  logic               wr_inside_q, wr_inside_d, overrun_q, overrun_d;
  logic [CNT_W-1:0]   total_q, total_d, inside_q, inside_d, total_inc, inside_inc;
  logic               lfsr_step, lfsr_load, accept;

  pi_lfsr #(.W(LFSR_W), .OUT_W(COORD_W), .SEED(SEED_X), .TAPS(TAPS_ALL[LFSR_W-1:0])) u_lfsr_x (
    .clk(clk), .reset_n(reset_n), .step(lfsr_step), .load(lfsr_load), .q(cand_x)
  );
  pi_lfsr #(.W(LFSR_W), .OUT_W(COORD_W), .SEED(SEED_Y), .TAPS(TAPS_ALL[LFSR_W-1:0])) u_lfsr_y (
    .clk(clk), .reset_n(reset_n), .step(lfsr_step), .load(lfsr_load), .q(cand_y)
  );

  logic signed [COORD_W:0]     dx, dy;
  logic signed [2*COORD_W+2:0] dx_w, dy_w;
  logic [2*COORD_W+2:0]        dist_sq;
  logic                        in_circle;

  always_comb begin
    dx        = $signed({1'b0, wr_x_q}) - $signed(RAD_C);
    dy        = $signed({1'b0, wr_y_q}) - $signed(RAD_C);
    dx_w      = (2*COORD_W+3)'(dx);
    dy_w      = (2*COORD_W+3)'(dy);
    dist_sq   = $unsigned(dx_w * dx_w + dy_w * dy_w);
    in_circle = dist_sq < RSQ_C;
  end

  always_comb begin
    state_d     = state_q;
    wr_x_d      = wr_x_q;
    wr_y_d      = wr_y_q;
    wr_inside_d = wr_inside_q;
    overrun_d   = overrun_q;
    total_d     = total_q;
    inside_d    = inside_q;
    lfsr_step   = 1'b0;
    lfsr_load   = 1'b0;
    accept      = 1'b0;
    total_inc   = (total_q == CNT_MAX) ? total_q : total_q + 1'b1;
    inside_inc  = (wr_inside_q && (inside_q != CNT_MAX)) ? inside_q + 1'b1 : inside_q;
    case (state_q)
      IDLE: if (enable && tick) state_d = GEN;
      GEN: begin
        lfsr_step = 1'b1;
        if (tick) overrun_d = 1'b1;
        if (({1'b0, cand_x} < SIDE_C) && ({1'b0, cand_y} < SIDE_C)) begin
          wr_x_d  = cand_x;
          wr_y_d  = cand_y;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (tick) overrun_d = 1'b1;
        wr_inside_d = in_circle;
        state_d     = WRITE;
      end
      WRITE: begin
        if (tick) overrun_d = 1'b1;
        if (wr_ready) begin
          accept   = 1'b1;
          total_d  = total_inc;
          inside_d = inside_inc;
          state_d  = ((SAMPLE_LIMIT != 0) && (total_inc == LIMIT_C)) ? DONE : IDLE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    // clear beats every other event, including an in-flight handshake
    if (clear) begin
      state_d   = IDLE;
      total_d   = '0;
      inside_d  = '0;
      overrun_d = 1'b0;
      lfsr_step = 1'b0;
      lfsr_load = 1'b1;
      accept    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_x_q      <= '0;
      wr_y_q      <= '0;
      wr_inside_q <= 1'b0;
      overrun_q   <= 1'b0;
      total_q     <= '0;
      inside_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_x_q      <= wr_x_d;
      wr_y_q      <= wr_y_d;
      wr_inside_q <= wr_inside_d;
      overrun_q   <= overrun_d;
      total_q     <= total_d;
      inside_q    <= inside_d;
    end
  end

  assign wr_valid     = (state_q == WRITE);
  assign done         = (state_q == DONE);
  assign wr_x         = wr_x_q;
  assign wr_y         = wr_y_q;
  assign wr_inside    = wr_inside_q;
  assign total_count  = total_q;
  assign inside_count = inside_q;
  assign overrun      = overrun_q;

`ifdef PI_SAMPLER_RATIO_EN
  // Restoring divider: inside/total as 16 fractional bits, i.e. 4*inside/total in Q2.14
  logic             div_busy_q, div_busy_d, div_fix_q, div_fix_d;
  logic             pi_est_valid_q, pi_est_valid_d;
  logic [4:0]       div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] div_rem_q, div_rem_d, div_den_q, div_den_d;
  logic [15:0]      div_quo_q, div_quo_d, pi_est_q, pi_est_d;
  logic [CNT_W:0]   div_shift;

  always_comb begin
    div_busy_d     = div_busy_q;
    div_fix_d      = div_fix_q;
    div_cnt_d      = div_cnt_q;
    div_rem_d      = div_rem_q;
    div_den_d      = div_den_q;
    div_quo_d      = div_quo_q;
    pi_est_d       = pi_est_q;
    pi_est_valid_d = pi_est_valid_q;
    div_shift      = {div_rem_q, 1'b0};
    if (clear) begin
      div_busy_d     = 1'b0;
      div_cnt_d      = '0;
      pi_est_d       = '0;
      pi_est_valid_d = 1'b0;
    end else if (accept) begin
      div_busy_d     = 1'b1;
      div_cnt_d      = 5'd16;
      div_rem_d      = inside_inc;
      div_den_d      = total_inc;
      // ratio of exactly 4.0 does not fit Q2.14, so it saturates
      div_fix_d      = (total_inc == '0) || (inside_inc >= total_inc);
      div_quo_d      = ((total_inc != '0) && (inside_inc >= total_inc)) ? 16'hFFFF : 16'h0000;
      pi_est_valid_d = 1'b0;
    end else if (div_busy_q) begin
      if (div_cnt_q != 5'd0) begin
        div_cnt_d = div_cnt_q - 5'd1;
        if (!div_fix_q) begin
          if (div_shift >= {1'b0, div_den_q}) begin
            div_rem_d = CNT_W'(div_shift - {1'b0, div_den_q});
            div_quo_d = {div_quo_q[14:0], 1'b1};
          end else begin
            div_rem_d = div_shift[CNT_W-1:0];
            div_quo_d = {div_quo_q[14:0], 1'b0};
          end
        end
      end else begin
        pi_est_d       = div_quo_q;
        pi_est_valid_d = 1'b1;
        div_busy_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_busy_q     <= 1'b0;
      div_fix_q      <= 1'b0;
      div_cnt_q      <= '0;
      div_rem_q      <= '0;
      div_den_q      <= '0;
      div_quo_q      <= '0;
      pi_est_q       <= '0;
      pi_est_valid_q <= 1'b0;
    end else begin
      div_busy_q     <= div_busy_d;
      div_fix_q      <= div_fix_d;
      div_cnt_q      <= div_cnt_d;
      div_rem_q      <= div_rem_d;
      div_den_q      <= div_den_d;
      div_quo_q      <= div_quo_d;
      pi_est_q       <= pi_est_d;
      pi_est_valid_q <= pi_est_valid_d;
    end
  end

  assign pi_est       = pi_est_q;
  assign pi_est_valid = pi_est_valid_q;
`endif

endmodule

// File: tb/tb_pi_sampler.sv
// Directed bench for pi_sampler: instance A (limit 5) and instance B (4-bit counters, rejecting seed).
module tb_pi_sampler;

  localparam logic [31:0] POLY   = 32'h8020_0003;
  localparam logic [31:0] SEED_AX = 32'hAAAACCCC;
  localparam logic [31:0] SEED_BX = 32'h123403E8;
  localparam logic [31:0] SEED_Y  = 32'hDECAFBAD;
  localparam int          SIDE   = 480;
  localparam int          R      = 240;
  localparam int          B_SAMPLES = 2000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic a_tick = 1'b0, a_enable = 1'b1, a_clear = 1'b0, a_wr_ready = 1'b0;
  logic b_tick = 1'b0, b_enable = 1'b1, b_clear = 1'b0, b_wr_ready = 1'b1;
  logic        a_wr_valid, a_wr_inside, a_done, a_overrun;
  logic [8:0]  a_wr_x, a_wr_y;
  logic [23:0] a_total, a_inside;
  logic        b_wr_valid, b_wr_inside, b_done, b_overrun;
  logic [8:0]  b_wr_x, b_wr_y;
  logic [3:0]  b_total, b_inside;

  pi_sampler #(.SAMPLE_LIMIT(5)) dut_a (
    .clk(clk), .reset_n(reset_n), .tick(a_tick), .enable(a_enable), .clear(a_clear),
    .wr_valid(a_wr_valid), .wr_ready(a_wr_ready), .wr_x(a_wr_x), .wr_y(a_wr_y),
    .wr_inside(a_wr_inside), .total_count(a_total), .inside_count(a_inside),
    .done(a_done), .overrun(a_overrun)
  );

  pi_sampler #(.CNT_W(4), .SEED_X(SEED_BX)) dut_b (
    .clk(clk), .reset_n(reset_n), .tick(b_tick), .enable(b_enable), .clear(b_clear),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_x(b_wr_x), .wr_y(b_wr_y),
    .wr_inside(b_wr_inside), .total_count(b_total), .inside_count(b_inside),
    .done(b_done), .overrun(b_overrun)
  );

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic       ins;
    logic [7:0] lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mx[2];
  logic [31:0] my[2];
  int n_pass = 0, n_fail = 0, n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  function automatic logic in_circ(input int x, input int y);
    int dx, dy;
    dx = x - R;
    dy = y - R;
    return (dx * dx + dy * dy) < R * R;
  endfunction

  // reference draw: both LFSRs step together until both coordinates land in the square
  task automatic push_expect(input int w);
    exp_t e;
    int draws, xi, yi;
    draws = 0;
    do begin
      mx[w] = lstep(mx[w]);
      my[w] = lstep(my[w]);
      draws++;
      xi = int'(mx[w][8:0]);
      yi = int'(my[w][8:0]);
    end while (!(xi < SIDE && yi < SIDE));
    e.x   = mx[w][8:0];
    e.y   = my[w][8:0];
    e.ins = in_circ(xi, yi);
    e.lat = 8'(draws + 2);
    sb.push_back(e);
  endtask

  // called and returns #1 after a rising edge; leaves the DUT presenting wr_valid
  task automatic start_and_wait(input int w, input string tag, output exp_t e, output int lat);
    logic v;
    push_expect(w);
    if (w == 1) b_tick = 1'b1;
    else        a_tick = 1'b1;
    @(posedge clk); #1;
    a_tick = 1'b0;
    b_tick = 1'b0;
    lat = 1;
    v = (w == 1) ? b_wr_valid : a_wr_valid;
    while (!v && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      v = (w == 1) ? b_wr_valid : a_wr_valid;
    end
    e = sb.pop_front();
    check({tag, "_latency"}, 32'(lat), 32'(e.lat));
    check({tag, "_x"}, 32'((w == 1) ? b_wr_x : a_wr_x), 32'(e.x));
    check({tag, "_y"}, 32'((w == 1) ? b_wr_y : a_wr_y), 32'(e.y));
    check({tag, "_inside"}, 32'((w == 1) ? b_wr_inside : a_wr_inside), 32'(e.ins));
  endtask

  task automatic accept_a;
    a_wr_ready = 1'b1;
    @(posedge clk); #1;
    a_wr_ready = 1'b0;
  endtask

  initial begin
    exp_t e;
    int lat, first_lat, exp_ins_a, exp_tot_b, exp_ins_b;
    logic [8:0] first_x, first_y;
    logic seen;

    mx[0] = SEED_AX; my[0] = SEED_Y;
    mx[1] = SEED_BX; my[1] = SEED_Y;
    exp_ins_a = 0;

    // reset held with tick active: nothing may move
    a_tick = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_a_ctl", 32'({a_wr_valid, a_wr_x, a_wr_y, a_wr_inside, a_done, a_overrun}), 32'h0);
      check("rst_a_cnt", 32'(a_total | a_inside), 32'h0);
      check("rst_b", 32'({b_wr_valid, b_wr_x, b_wr_y, b_wr_inside, b_total, b_inside, b_done, b_overrun}), 32'h0);
    end
    reset_n = 1'b1;
    a_tick  = 1'b0;
    @(posedge clk); #1;

    // first sample after reset: 3-cycle latency, golden point
    start_and_wait(0, "first", e, lat);
    first_x = e.x;
    first_y = e.y;
    accept_a();
    exp_ins_a += int'(e.ins);
    check("first_total", 32'(a_total), 32'd1);
    check("first_inside_cnt", 32'(a_inside), 32'(exp_ins_a));
    check("first_valid_drop", 32'(a_wr_valid), 32'd0);

    // backpressure with an overrunning tick in the middle
    start_and_wait(0, "stall", e, lat);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) a_tick = 1'b1;
      @(posedge clk); #1;
      a_tick = 1'b0;
      check("stall_hold", 32'({a_wr_valid, a_wr_x, a_wr_y, a_wr_inside}), 32'({1'b1, e.x, e.y, e.ins}));
      check("stall_total", 32'(a_total), 32'd1);
    end
    check("stall_overrun", 32'(a_overrun), 32'd1);
    accept_a();
    exp_ins_a += int'(e.ins);
    check("stall_release_total", 32'(a_total), 32'd2);

    // tick with enable low is dropped
    a_enable = 1'b0;
    a_tick   = 1'b1;
    @(posedge clk); #1;
    a_tick   = 1'b0;
    a_enable = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen |= a_wr_valid;
    end
    check("enable_low_drop", 32'(seen), 32'd0);

    // samples 3..5 reach SAMPLE_LIMIT
    for (int k = 3; k <= 5; k++) begin
      repeat (3) @(posedge clk);
      #1;
      start_and_wait(0, "limit", e, lat);
      accept_a();
      exp_ins_a += int'(e.ins);
      check("limit_done", 32'(a_done), 32'(k == 5));
      check("limit_total", 32'(a_total), 32'(k));
    end
    check("limit_inside_cnt", 32'(a_inside), 32'(exp_ins_a));
    a_tick = 1'b1;
    @(posedge clk); #1;
    a_tick = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      seen |= a_wr_valid;
    end
    check("done_ignores_tick", 32'(seen), 32'd0);
    check("done_held", 32'(a_done), 32'd1);

    // clear out of DONE
    a_clear = 1'b1;
    @(posedge clk); #1;
    a_clear = 1'b0;
    mx[0] = SEED_AX; my[0] = SEED_Y;
    check("clear_counts", 32'({a_total, 8'h00} | {8'h00, a_inside}), 32'd0);
    check("clear_flags", 32'({a_done, a_overrun, a_wr_valid}), 32'd0);
    start_and_wait(0, "post_clear", e, lat);
    check("post_clear_first_pt", 32'({a_wr_x, a_wr_y}), 32'({first_x, first_y}));
    accept_a();
    check("post_clear_total", 32'(a_total), 32'd1);

    // clear while presenting a write withdraws it without a handshake
    a_clear = 1'b1;
    @(posedge clk); #1;
    a_clear = 1'b0;
    mx[0] = SEED_AX; my[0] = SEED_Y;
    start_and_wait(0, "clr_wr", e, lat);
    a_clear = 1'b1;
    @(posedge clk); #1;
    a_clear = 1'b0;
    mx[0] = SEED_AX; my[0] = SEED_Y;
    check("clr_wr_valid", 32'(a_wr_valid), 32'd0);
    check("clr_wr_total", 32'(a_total), 32'd0);
    start_and_wait(0, "after_clr_wr", e, lat);
    check("after_clr_wr_first_pt", 32'({a_wr_x, a_wr_y}), 32'({first_x, first_y}));
    accept_a();

    // instance B: rejection sampling and counter saturation
    exp_tot_b = 0;
    exp_ins_b = 0;
    first_lat = 0;
    for (int i = 0; i < B_SAMPLES; i++) begin
      start_and_wait(1, "b", e, lat);
      if (i == 0) first_lat = lat;
      check("b_range", 32'((int'(b_wr_x) < SIDE) && (int'(b_wr_y) < SIDE)), 32'd1);
      @(posedge clk); #1;
      if (exp_tot_b < 15) exp_tot_b++;
      if (e.ins && exp_ins_b < 15) exp_ins_b++;
    end
    check("b_first_rejected", 32'(first_lat > 3), 32'd1);
    check("b_total_sat", 32'(b_total), 32'(exp_tot_b));
    check("b_inside_sat", 32'(b_inside), 32'(exp_ins_b));
    check("b_flags", 32'({b_done, b_overrun, b_wr_valid}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
